serial_adder: RTL

Bit-serial N-bit adder that consumes one `full_adder` per bit-time and a single carry flip-flop. It replaces a WIDTH-wide ripple chain with one adder cell iterated over WIDTH clock cycles. It sits directly downstream of the basic `full_adder` and `d_flip_flop` cells: it feeds them operand bits LSB-first and collects their sum and carry outputs. Operands are loaded in parallel on a start handshake, and the result is presented in parallel with a one-cycle done pulse.

---
 rtl/serial_adder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell iterated LSB-first over WIDTH cycles,
// with parallel operand load on start and a registered result plus done pulse.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module d_flip_flop (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int unsigned CNT_W = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             carry_d;
    logic             carry_en;
    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             shift_en;
    logic             last;

    assign load     = (state == IDLE) && start;
    assign shift_en = (state == SHIFT);
    assign last     = shift_en && (cnt == LAST_BIT);

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Carry is seeded with c_in on load, then follows the adder carry each bit.
    assign carry_en = load | shift_en;
    assign carry_d  = shift_en ? fa_co : c_in;

    d_flip_flop u_carry (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (carry_en),
        .d     (carry_d),
        .q     (carry)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_acc_one
            assign acc_nxt = fa_s;
        end else begin : g_acc_wide
            assign acc_nxt = {fa_s, acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            acc  <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            acc  <= acc_nxt;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Result holding registers: updated only on the final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else if (last) begin
            sum   <= acc_nxt;
            c_out <= fa_co;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (state_nxt != IDLE) busy_nxt = 1'b1;
        if (state_nxt == DONE) done_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end
endmodule
